goertzel_frame_tx: RTL and testbench

- Downstream of parallel_goertzel and upstream of uart_controller, all on clk_24M.
- Captures the Goertzel bin magnitudes when G_READY pulses, together with the run index.
- Serializes them into a fixed byte frame: sync, run, bins MSB-first, terminator.
- Drives the uart_controller TX_DATA/TX_LOAD/TX_LOAD_OKAY handshake, with one-deep pending buffering and drop counting.

---
 rtl/gft_pkg.sv | 31 +++
 rtl/gft_byte_mux.sv | 51 +++++
 rtl/goertzel_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_goertzel_frame_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gft_pkg.sv
// ============================================================================
// Module : gft_pkg
// Brief  : Shared FSM encoding, default frame bytes and frame-length helper
//          for goertzel_frame_tx. GFT_CHECKSUM_EN adds a checksum byte.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package gft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_NEXT     = 2'd3
  } gft_state_t;

  localparam logic [7:0] c_sync_byte_default = 8'hA5;
  localparam logic [7:0] c_term_byte_default = 8'h0A;

  function automatic int gft_frame_len(input int num_bins);
`ifdef GFT_CHECKSUM_EN
    return 4 + 2 * num_bins;
`else
    return 3 + 2 * num_bins;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/gft_byte_mux.sv
// ============================================================================
// Module : gft_byte_mux
// Brief  : Combinational frame-layout selector: byte[idx] of the current frame.
//          GFT_CHECKSUM_EN adds the checksum input placed before TERM_BYTE.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module gft_byte_mux
  import gft_pkg::*;
#(
  parameter int         NUM_BINS  = 2,
  parameter int         MAG_W     = 16,
  parameter logic [7:0] SYNC_BYTE = c_sync_byte_default,
  parameter logic [7:0] TERM_BYTE = c_term_byte_default,
  parameter int         IDX_W     = 3
) (
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [NUM_BINS*MAG_W-1:0] mag_i,
  input  logic [4:0]                run_i,
`ifdef GFT_CHECKSUM_EN
  input  logic [7:0]                csum_i,
`endif
  output logic [7:0]                byte_o
);

`ifdef GFT_CHECKSUM_EN
  localparam int FL = gft_frame_len(NUM_BINS);
`endif

  always_comb begin
    byte_o = TERM_BYTE;
    if (idx_i == '0) begin
      byte_o = SYNC_BYTE;
    end else if (idx_i == IDX_W'(1)) begin
      byte_o = {3'b000, run_i};
    end else begin
      // Bin b occupies indices 2+2b (MSB) and 3+2b (LSB).
      for (int b = 0; b < NUM_BINS; b++) begin
        if (idx_i == IDX_W'(2 + 2 * b)) byte_o = mag_i[b*MAG_W + MAG_W - 8 +: 8];
        if (idx_i == IDX_W'(3 + 2 * b)) byte_o = mag_i[b*MAG_W +: 8];
      end
`ifdef GFT_CHECKSUM_EN
      if (idx_i == IDX_W'(FL - 2)) byte_o = csum_i;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/goertzel_frame_tx.sv
// ============================================================================
// Module : goertzel_frame_tx
// Brief  : Captures Goertzel magnitudes on g_ready and streams them as a byte
//          frame over the UART load handshake. GFT_CHECKSUM_EN adds a checksum.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module goertzel_frame_tx
  import gft_pkg::*;
#(
  parameter int          NUM_BINS    = 2,
  parameter int          MAG_W       = 16,
  parameter logic [7:0]  SYNC_BYTE   = c_sync_byte_default,
  parameter logic [7:0]  TERM_BYTE   = c_term_byte_default,
  parameter logic [31:0] RUN_MASK    = 32'hFFFF_FFFF,
  parameter int          ACK_TIMEOUT = 4
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      g_ready,
  input  logic [NUM_BINS*MAG_W-1:0] g_mag,
  input  logic [4:0]                run_idx,
  output logic [7:0]                tx_data,
  output logic                      tx_load,
  input  logic                      tx_load_okay,
  output logic                      busy,
  output logic [7:0]                drop_cnt
);

  localparam int FL    = gft_frame_len(NUM_BINS);
  localparam int IDX_W = (FL > 2) ? $clog2(FL) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  gft_state_t                state_q;
  logic [IDX_W-1:0]          idx_q;
  logic [TMR_W-1:0]          tmr_q;
  logic [NUM_BINS*MAG_W-1:0] shd_mag_q;
  logic [4:0]                shd_run_q;
  logic [NUM_BINS*MAG_W-1:0] pend_mag_q;
  logic [4:0]                pend_run_q;
  logic                      pend_v_q;
  logic [7:0]                tx_data_q;
  logic                      tx_load_q;
  logic                      busy_q;
  logic [7:0]                drop_cnt_q;
  logic [7:0]                drop_cnt_d;
  logic                      capture_w;
  logic [7:0]                byte_w;
`ifdef GFT_CHECKSUM_EN
  logic [7:0]                csum_q;
`endif

  assign capture_w = g_ready && en && RUN_MASK[run_idx];

  // A capture landing on a valid pending slot is an overwrite, at any state.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (capture_w && pend_v_q && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  gft_byte_mux #(
    .NUM_BINS  (NUM_BINS),
    .MAG_W     (MAG_W),
    .SYNC_BYTE (SYNC_BYTE),
    .TERM_BYTE (TERM_BYTE),
    .IDX_W     (IDX_W)
  ) u_byte_mux (
    .idx_i  (idx_q),
    .mag_i  (shd_mag_q),
    .run_i  (shd_run_q),
`ifdef GFT_CHECKSUM_EN
    .csum_i (csum_q),
`endif
    .byte_o (byte_w)
  );

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      shd_mag_q  <= '0;
      shd_run_q  <= '0;
      pend_mag_q <= '0;
      pend_run_q <= '0;
      pend_v_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_load_q  <= 1'b0;
      busy_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
`ifdef GFT_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      tx_load_q  <= 1'b0;
      drop_cnt_q <= drop_cnt_d;
      if (capture_w && (state_q != ST_IDLE)) begin
        pend_mag_q <= g_mag;
        pend_run_q <= run_idx;
        pend_v_q   <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (capture_w) begin
            shd_mag_q <= g_mag;
            shd_run_q <= run_idx;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_LOAD;
`ifdef GFT_CHECKSUM_EN
            csum_q    <= 8'h00;
`endif
          end
        end
        ST_LOAD: begin
          if (tx_load_okay) begin
            tx_data_q <= byte_w;
            tx_load_q <= 1'b1;
            tmr_q     <= '0;
            state_q   <= ST_WAIT_ACK;
`ifdef GFT_CHECKSUM_EN
            if ((idx_q != '0) && (idx_q < IDX_W'(FL - 2))) csum_q <= csum_q + byte_w;
`endif
          end
        end
        ST_WAIT_ACK: begin
          if (!tx_load_okay || (tmr_q == TMR_W'(ACK_TIMEOUT - 1))) state_q <= ST_NEXT;
          else tmr_q <= tmr_q + 1'b1;
        end
        ST_NEXT: begin
          if (idx_q == IDX_W'(FL - 1)) begin
            // A capture this very cycle wins the promotion so it is never lost.
            if (capture_w || pend_v_q) begin
              shd_mag_q <= capture_w ? g_mag : pend_mag_q;
              shd_run_q <= capture_w ? run_idx : pend_run_q;
              pend_v_q  <= 1'b0;
              idx_q     <= '0;
              state_q   <= ST_LOAD;
`ifdef GFT_CHECKSUM_EN
              csum_q    <= 8'h00;
`endif
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= ST_LOAD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_load  = tx_load_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_goertzel_frame_tx.sv
// ============================================================================
// Module : tb_goertzel_frame_tx
// Brief  : Directed self-checking bench for goertzel_frame_tx with a small UART
//          handshake model. Honors GFT_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_goertzel_frame_tx;

`ifdef GFT_CHECKSUM_EN
  localparam int FL = 8;
`else
  localparam int FL = 7;
`endif

  // Frame tables: bytes 0..5, checksum, terminator (MSB byte first).
  localparam logic [63:0] F1 = 64'hA5_03_AB_CD_12_34_C1_0A;
  localparam logic [63:0] FA = 64'hA5_01_03_04_01_02_0B_0A;
  localparam logic [63:0] FC = 64'hA5_04_00_FF_FF_00_02_0A;
  localparam logic [31:0] M1 = 32'h1234_ABCD;
  localparam logic [31:0] MA = 32'h0102_0304;
  localparam logic [31:0] MB = 32'h5555_6666;
  localparam logic [31:0] MC = 32'hFF00_00FF;

  logic        sys_clk, rst_n, en, g_ready, g_ready_m;
  logic [31:0] g_mag;
  logic [4:0]  run_idx;
  logic [7:0]  tx_data, tx_data_m, drop_cnt, drop_cnt_m;
  logic        tx_load, tx_load_m, tx_load_okay, tx_load_okay_m, busy, busy_m;
  logic        stall;
  int          ucnt;
  int          n_checks, n_fail;
  int          npulse, npulse_m;
  logic [7:0]  q[$];
  logic [7:0]  qm[$];

  goertzel_frame_tx dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .g_ready(g_ready), .g_mag(g_mag),
    .run_idx(run_idx), .tx_data(tx_data), .tx_load(tx_load),
    .tx_load_okay(tx_load_okay), .busy(busy), .drop_cnt(drop_cnt)
  );

  goertzel_frame_tx #(.RUN_MASK(32'h0000_0008)) dut_m (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .g_ready(g_ready_m), .g_mag(g_mag),
    .run_idx(run_idx), .tx_data(tx_data_m), .tx_load(tx_load_m),
    .tx_load_okay(tx_load_okay_m), .busy(busy_m), .drop_cnt(drop_cnt_m)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [7:0] exp_byte(input logic [63:0] tbl, input int i);
`ifdef GFT_CHECKSUM_EN
    return tbl[63-8*i -: 8];
`else
    return (i < 6) ? tbl[63-8*i -: 8] : tbl[7:0];
`endif
  endfunction

  // UART: drops okay for two cycles after each load, or while stalled.
  initial begin
    tx_load_okay   = 1'b1;
    tx_load_okay_m = 1'b1;
    ucnt           = 0;
    forever begin
      @(negedge sys_clk);
      if (tx_load) ucnt = 2;
      else if (ucnt > 0) ucnt--;
      tx_load_okay = !stall && (ucnt == 0);
    end
  end

  initial begin
    npulse   = 0;
    npulse_m = 0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (tx_load) begin q.push_back(tx_data); npulse++; end
      if (tx_load_m) begin qm.push_back(tx_data_m); npulse_m++; end
    end
  end

  task automatic pulse(input logic [4:0] r, input logic [31:0] m);
    @(negedge sys_clk);
    g_ready = 1'b1; run_idx = r; g_mag = m;
    @(negedge sys_clk);
    g_ready = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes(input int nb, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (q.size() >= nb) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b1; g_ready = 1'b0; g_ready_m = 1'b0;
    g_mag = '0; run_idx = '0; stall = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_checks++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL reset_tx_load got=%b exp=0", tx_load); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop got=%h exp=00", drop_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single_frame;
    int n0; bit ok; logic [7:0] got, exp;
    q.delete(); n0 = npulse;
    pulse(5'd3, M1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_rise got=%b exp=1", busy); end
    wait_idle(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout got=busy exp=idle"); end
    n_checks++; if (npulse - n0 !== FL) begin n_fail++; $display("FAIL single_count got=%0d exp=%0d", npulse - n0, FL); end
    for (int i = 0; i < FL; i++) begin
      got = (i < q.size()) ? q[i] : 8'hEE;
      exp = exp_byte(F1, i);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL single_byte%0d got=%h exp=%h", i, got, exp); end
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_enable;
    int n0;
    n0 = npulse; en = 1'b0;
    pulse(5'd3, M1);
    repeat (10) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL en_low_busy got=%b exp=0", busy); end
    n_checks++; if (npulse !== n0) begin n_fail++; $display("FAIL en_low_loads got=%0d exp=%0d", npulse - n0, 0); end
    en = 1'b1;
  endtask

  task automatic test_backpressure;
    int n0, n1; bit ok; logic [7:0] got, exp;
    q.delete(); n0 = npulse;
    pulse(5'd3, M1);
    wait_bytes(3, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_start_timeout got=%0d exp>=3", q.size()); end
    stall = 1'b1;
    @(negedge sys_clk);
    n1 = npulse;
    repeat (50) @(negedge sys_clk);
    n_checks++; if (npulse !== n1) begin n_fail++; $display("FAIL bp_stall_loads got=%0d exp=0", npulse - n1); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_stall_busy got=%b exp=1", busy); end
    stall = 1'b0;
    wait_idle(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got=busy exp=idle"); end
    n_checks++; if (npulse - n0 !== FL) begin n_fail++; $display("FAIL bp_count got=%0d exp=%0d", npulse - n0, FL); end
    for (int i = 0; i < FL; i++) begin
      got = (i < q.size()) ? q[i] : 8'hEE;
      exp = exp_byte(F1, i);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got, exp); end
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_overrun;
    bit ok; logic [7:0] got, exp;
    q.delete();
    pulse(5'd1, MA);
    pulse(5'd2, MB);
    pulse(5'd4, MC);
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovr_drop got=%0d exp=1", drop_cnt); end
    wait_idle(400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovr_timeout got=busy exp=idle"); end
    n_checks++; if (q.size() !== 2 * FL) begin n_fail++; $display("FAIL ovr_count got=%0d exp=%0d", q.size(), 2 * FL); end
    for (int i = 0; i < 2 * FL; i++) begin
      got = (i < q.size()) ? q[i] : 8'hEE;
      exp = (i < FL) ? exp_byte(FA, i) : exp_byte(FC, i - FL);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ovr_byte%0d got=%h exp=%h", i, got, exp); end
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_saturate;
    bit ok;
    @(negedge sys_clk);
    g_ready = 1'b1; run_idx = 5'd2; g_mag = MB;
    repeat (300) @(negedge sys_clk);
    g_ready = 1'b0;
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_drop got=%0d exp=255", drop_cnt); end
    wait_idle(500, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_timeout got=busy exp=idle"); end
    n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_run_mask;
    int n0; logic [7:0] got;
    qm.delete(); n0 = npulse_m;
    for (int r = 0; r < 5; r++) begin
      @(negedge sys_clk);
      g_ready_m = 1'b1; run_idx = 5'(r); g_mag = M1;
      @(negedge sys_clk);
      g_ready_m = 1'b0;
      repeat (70) @(negedge sys_clk);
    end
    n_checks++; if (npulse_m - n0 !== FL) begin n_fail++; $display("FAIL mask_count got=%0d exp=%0d", npulse_m - n0, FL); end
    got = (qm.size() > 1) ? qm[1] : 8'hEE;
    n_checks++; if (got !== 8'h03) begin n_fail++; $display("FAIL mask_run got=%h exp=03", got); end
    n_checks++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL mask_busy got=%b exp=0", busy_m); end
  endtask

  task automatic test_reset_mid;
    int n1; bit ok; logic [7:0] got, exp;
    q.delete();
    pulse(5'd3, M1);
    wait_bytes(3, 100, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_start_timeout got=%0d exp>=3", q.size()); end
    rst_n = 1'b0;
    @(negedge sys_clk);
    n_checks++; if (tx_load !== 1'b0) begin n_fail++; $display("FAIL rmid_tx_load got=%b exp=0", tx_load); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rmid_drop got=%0d exp=0", drop_cnt); end
    rst_n = 1'b1;
    n1 = npulse;
    repeat (20) @(negedge sys_clk);
    n_checks++; if (npulse !== n1) begin n_fail++; $display("FAIL rmid_resume got=%0d exp=0", npulse - n1); end
    q.delete();
    pulse(5'd3, M1);
    wait_idle(200, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout got=busy exp=idle"); end
    n_checks++; if (q.size() !== FL) begin n_fail++; $display("FAIL rmid_count got=%0d exp=%0d", q.size(), FL); end
    for (int i = 0; i < FL; i++) begin
      got = (i < q.size()) ? q[i] : 8'hEE;
      exp = exp_byte(F1, i);
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, got, exp); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_frame();
    test_enable();
    test_backpressure();
    test_overrun();
    test_saturate();
    test_run_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
